hex_display_scan: RTL and testbench



---
 rtl/display_pkg.sv | 28 ++
 rtl/hex_to_seg.sv | 33 +++
 rtl/hex_display_scan.sv | 116 +++++++++++
 tb/tb_hex_display_scan.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path: segment patterns for
// hex digits 0-F (active-high, bit order {g,f,e,d,c,b,a}) and the blank code.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scan.sv
// Four-digit multiplexed 7-segment driver. A prescaler steps the lit digit,
// the input word is latched into a shadow register once per scan frame so a
// frame never mixes two values, and the segment/anode outputs are registered.
module hex_display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    // Inactive levels of the pin-facing outputs for the selected polarity
    localparam logic [6:0]  SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF   = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic        DP_OFF   = ACTIVE_LOW;

    logic [15:0] div_cnt;
    digit_idx_t  idx;
    logic [15:0] shadow;
    logic [3:0]  dp_shadow;
    logic        first;

    logic        at_term;
    logic        capture;
    logic [3:0]  cur_nibble;
    logic [6:0]  cur_seg;
    logic        blank;
    logic [3:0]  an_dec;
    logic [6:0]  seg_dec;
    logic        dp_dec;

    assign at_term    = (div_cnt == DIV_LAST);
    // Capture once after reset and again whenever the scan wraps 3 -> 0
    assign capture    = first || (at_term && (idx == 2'd3));
    assign cur_nibble = shadow[{idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Leading-zero blanking: digit idx is dark when it and every digit to its
    // left are zero and it carries no decimal point; digit 0 always shows
    always_comb begin
        blank = 1'b0;
        if (BLANK_LEADING && (idx != 2'd0)) begin
            blank = ((shadow >> {idx, 2'b00}) == 16'd0) && !dp_shadow[idx];
        end
    end

    // Decode of the current digit, polarity applied last
    always_comb begin
        an_dec  = 4'b0001 << idx;
        seg_dec = blank ? SEG_BLANK : cur_seg;
        dp_dec  = dp_shadow[idx];
        if (ACTIVE_LOW) begin
            an_dec  = ~an_dec;
            seg_dec = ~seg_dec;
            dp_dec  = ~dp_dec;
        end
    end

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 16'd0;
            idx     <= 2'd0;
        end else if (at_term) begin
            div_cnt <= 16'd0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Shadow capture of the display word and the frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= 16'd0;
            dp_shadow  <= 4'd0;
            first      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= capture;
            if (capture) begin
                shadow    <= data_in;
                dp_shadow <= dp_in;
                first     <= 1'b0;
            end
        end
    end

    // Registered pin outputs; they reflect the pre-edge index and shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= an_dec;
            seg <= seg_dec;
            dp  <= dp_dec;
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: two instances (common-anode with blanking, and
// active-high without blanking) compared every cycle with a frame-level model.
module tb_hex_display_scan;

    localparam int SD = 4;

    logic clk = 1'b0;
    bit   clk_run = 1'b1;

    logic        rst_n, rst_n_b;
    logic [15:0] data_in, data_b;
    logic [3:0]  dp_in, dp_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b_out;
    logic [3:0]  an_a, an_b;
    logic        ft_a, ft_b;

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset release and captured words
    int          ea, eb;
    logic [15:0] sha, shb;
    logic [3:0]  dsa, dsb;
    logic [3:0]  m_an_a, m_an_b;
    logic [6:0]  m_seg_a, m_seg_b;
    logic        m_dp_a, m_dp_b, m_ft_a, m_ft_b;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_display_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_tick(ft_a));

    hex_display_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .data_in(data_b), .dp_in(dp_b),
        .seg(seg_b), .dp(dp_b_out), .an(an_b), .frame_tick(ft_b));

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [6:0] ref_seg(logic [15:0] v, logic [3:0] d, int i, bit al, bit bl);
        logic [6:0] p;
        int n;
        n = int'((v >> (4 * i)) & 16'hF);
        p = seg_tbl[n];
        if (bl && i > 0 && (v >> (4 * i)) == 16'd0 && !d[i]) p = 7'h00;
        return al ? ~p : p;
    endfunction

    function automatic logic [3:0] ref_an(int i, bit al);
        logic [3:0] o;
        o = 4'b0001 << i;
        return al ? ~o : o;
    endfunction

    task automatic reset_model_a();
        ea = 0; sha = 16'h0; dsa = 4'h0;
        m_an_a = 4'hF; m_seg_a = 7'h7F; m_dp_a = 1'b1; m_ft_a = 1'b0;
    endtask

    task automatic reset_model_b();
        eb = 0; shb = 16'h0; dsb = 4'h0;
        m_an_b = 4'h0; m_seg_b = 7'h00; m_dp_b = 1'b0; m_ft_b = 1'b0;
    endtask

    // Advance one clock; the model computes what each edge must produce
    task automatic tick();
        int ip;
        bit cap;
        @(posedge clk);
        if (rst_n) begin
            ip  = (ea / SD) % 4;
            cap = (ea == 0) || (ea % (4 * SD) == 4 * SD - 1);
            m_an_a  = ref_an(ip, 1'b1);
            m_seg_a = ref_seg(sha, dsa, ip, 1'b1, 1'b1);
            m_dp_a  = ~dsa[ip];
            m_ft_a  = cap;
            if (cap) begin sha = data_in; dsa = dp_in; end
            ea++;
        end
        if (rst_n_b) begin
            ip  = (eb / SD) % 4;
            cap = (eb == 0) || (eb % (4 * SD) == 4 * SD - 1);
            m_an_b  = ref_an(ip, 1'b0);
            m_seg_b = ref_seg(shb, dsb, ip, 1'b0, 1'b0);
            m_dp_b  = dsb[ip];
            m_ft_b  = cap;
            if (cap) begin shb = data_b; dsb = dp_b; end
            eb++;
        end
        #1;
    endtask

    task automatic test_reset();
        data_in = 16'h12AF; dp_in = 4'h0; data_b = 16'h0000; dp_b = 4'h0;
        rst_n = 1'b1; rst_n_b = 1'b1;
        #2;
        rst_n = 1'b0; rst_n_b = 1'b0;
        reset_model_a(); reset_model_b();
        #1;
        checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an_a); end
        checks++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", seg_a); end
        checks++; if (dp_a !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp_a); end
        checks++; if (ft_a !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b want 0", ft_a); end
        checks++; if ({an_b, seg_b, dp_b_out, ft_b} !== 13'h0) begin
            errors++; $display("FAIL reset_b: got an=%b seg=%h dp=%b ft=%b want all 0", an_b, seg_b, dp_b_out, ft_b);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({an_a, seg_a, dp_a, ft_a} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++; $display("FAIL reset_hold cyc %0d: got an=%b seg=%h dp=%b ft=%b", c, an_a, seg_a, dp_a, ft_a);
            end
        end
    endtask

    task automatic test_basic_scan();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({an_a, seg_a, dp_a, ft_a} !== {m_an_a, m_seg_a, m_dp_a, m_ft_a}) begin
                errors++; $display("FAIL basic_start cyc %0d: got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                                   c, an_a, seg_a, dp_a, ft_a, m_an_a, m_seg_a, m_dp_a, m_ft_a);
            end
        end
        checks++;
        if (an_a !== 4'b1110 || seg_a !== 7'h0E) begin
            errors++; $display("FAIL basic_digit0_F: got an=%b seg=%h want an=1110 seg=0e", an_a, seg_a);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++;
            if ({an_a, seg_a, dp_a, ft_a} !== {m_an_a, m_seg_a, m_dp_a, m_ft_a}) begin
                errors++; $display("FAIL basic cyc %0d: got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                                   c, an_a, seg_a, dp_a, ft_a, m_an_a, m_seg_a, m_dp_a, m_ft_a);
            end
        end
    endtask

    task automatic test_tearing();
        bit seen;
        data_in = 16'h1234;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            seen = m_ft_a;
            checks++;
            if ({an_a, seg_a, dp_a, ft_a} !== {m_an_a, m_seg_a, m_dp_a, m_ft_a}) begin
                errors++; $display("FAIL tear_sync cyc %0d: got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b",
                                   c, an_a, seg_a, ft_a, m_an_a, m_seg_a, m_ft_a);
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL tear_capture: got no frame_tick want one within 40 cycles"); end
        for (int c = 0; c < SD + 1; c++) tick();
        data_in = 16'h5678;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = (an_a === 4'b0111);
        end
        checks++;
        if (!seen || seg_a !== 7'h79) begin
            errors++; $display("FAIL tear_digit3_old: got an=%b seg=%h want an=0111 seg=79", an_a, seg_a);
        end
        for (int c = 0; c < 36; c++) begin
            tick();
            checks++;
            if ({an_a, seg_a, dp_a, ft_a} !== {m_an_a, m_seg_a, m_dp_a, m_ft_a}) begin
                errors++; $display("FAIL tear cyc %0d: got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b",
                                   c, an_a, seg_a, ft_a, m_an_a, m_seg_a, m_ft_a);
            end
        end
    endtask

    task automatic test_blank_and_dp();
        logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0007};
        logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b0100};
        for (int t = 0; t < 3; t++) begin
            data_in = vals[t]; dp_in = dps[t];
            for (int c = 0; c < 40; c++) begin
                tick();
                checks++;
                if ({an_a, seg_a, dp_a, ft_a} !== {m_an_a, m_seg_a, m_dp_a, m_ft_a}) begin
                    errors++; $display("FAIL blank %h/%b cyc %0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                                       vals[t], dps[t], c, an_a, seg_a, dp_a, m_an_a, m_seg_a, m_dp_a);
                end
                if (c >= 24 && t == 2 && an_a === 4'b1011) begin
                    checks++;
                    if (seg_a !== 7'h40 || dp_a !== 1'b0) begin
                        errors++; $display("FAIL dp_digit2: got seg=%h dp=%b want seg=40 dp=0", seg_a, dp_a);
                    end
                end
            end
        end
        dp_in = 4'h0;
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 6; c++) tick();
        clk_run = 1'b0;
        #3;
        rst_n = 1'b0;
        reset_model_a();
        #1;
        checks++;
        if ({an_a, seg_a, dp_a, ft_a} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL async_reset: got an=%b seg=%h dp=%b ft=%b want 1111 7f 1 0", an_a, seg_a, dp_a, ft_a);
        end
        data_in = 16'hBEEF;
        #10;
        rst_n = 1'b1;
        #10;
        clk_run = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({an_a, seg_a, dp_a, ft_a} !== {m_an_a, m_seg_a, m_dp_a, m_ft_a}) begin
                errors++; $display("FAIL after_reset cyc %0d: got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b",
                                   c, an_a, seg_a, ft_a, m_an_a, m_seg_a, m_ft_a);
            end
            if (c == 1) begin
                checks++;
                if (an_a !== 4'b1110 || seg_a !== 7'h0E) begin
                    errors++; $display("FAIL recapture: got an=%b seg=%h want an=1110 seg=0e", an_a, seg_a);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            tick();
            checks++;
            if ({an_a, seg_a, dp_a, ft_a} !== {m_an_a, m_seg_a, m_dp_a, m_ft_a}) begin
                errors++; $display("FAIL random cyc %0d: got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                                   c, an_a, seg_a, dp_a, ft_a, m_an_a, m_seg_a, m_dp_a, m_ft_a);
            end
        end
    endtask

    task automatic test_active_high_no_blank();
        int pulses;
        pulses = 0;
        rst_n_b = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            tick();
            if (c >= 17 && ft_b === 1'b1) pulses++;
            checks++;
            if ({an_b, seg_b, dp_b_out, ft_b} !== {m_an_b, m_seg_b, m_dp_b, m_ft_b}) begin
                errors++; $display("FAIL active_high cyc %0d: got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                                   c, an_b, seg_b, dp_b_out, ft_b, m_an_b, m_seg_b, m_dp_b, m_ft_b);
            end
            if (c >= 2 && seg_b !== 7'h3F) begin
                checks++; errors++;
                $display("FAIL active_high_zero cyc %0d: got seg=%h want 3f", c, seg_b);
            end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL frame_period: got %0d pulses want 2 in 32 cycles", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tearing();
        test_blank_and_dp();
        test_async_reset();
        test_random();
        test_active_high_no_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
